axi4lite_cmd_master: RTL and testbench
======================================

// Module: axi4lite_cmd_master
// PURPOSE
//  Converts a simple single-beat command port into AXI4-Lite master transactions.
//  Drives the slave side of the AXI4-Lite interface, i.e. the bridge's AXI4-Lite slave (awaddr..rready).
//  Intended users: on-chip bus initiators and the bridge testbench.
//  One transaction outstanding at a time; write response / read data returned as a one-cycle pulse.
// PARAMETERS
//  DATA_WIDTH  32      AXI data width; WSTRB width = DATA_WIDTH/8
//  ADDR_WIDTH  32      AXI address width
//  PROT        3'b000  constant driven on awprot/arprot
// PORTS
//  aclk        in   1             clock, all logic on rising edge
//  areset      in   1             reset, asynchronous, active-high
//  req_valid   in   1             command valid
//  req_ready   out  1             command accepted when req_valid&&req_ready
//  req_write   in   1             1=write, 0=read
//  req_addr    in   ADDR_WIDTH    byte address
//  req_wdata   in   DATA_WIDTH    write data (ignored for reads)
//  req_wstrb   in   DATA_WIDTH/8  byte strobes (ignored for reads)
//  resp_valid  out  1             one-cycle completion pulse, no backpressure
//  resp_write  out  1             echo of req_write for the completed command
//  resp_code   out  2             BRESP or RRESP as received
//  resp_err    out  1             resp_code != 2'b00
//  resp_rdata  out  DATA_WIDTH    RDATA (0 on writes)
//  awaddr/awprot/awvalid out, awready in   AW channel
//  wdata/wstrb/wvalid out, wready in       W channel
//  bresp in 2, bvalid in, bready out       B channel
//  araddr/arprot/arvalid out, arready in   AR channel
//  rdata in, rresp in 2, rvalid in, rready out   R channel
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE. All valids, bready, rready, req_ready, resp_valid = 0.
//   All address/data/resp regs = 0. req_ready rises on the first aclk edge after areset falls.
//  FSM: IDLE -> WR_AW_W -> WR_B -> IDLE; IDLE -> RD_AR -> RD_R -> IDLE.
//  IDLE: req_ready=1. On accept, latch command, req_ready->0, go WR_AW_W or RD_AR.
//  WR_AW_W: awvalid and wvalid rise together on the edge after accept.
//   Track aw_done/w_done independently. Each valid falls on the edge after its own handshake.
//   Handshakes may occur in either order or the same cycle.
//   Go WR_B on the edge where the last of the two completes.
//  WR_B: bready=1. On bvalid: latch bresp, pulse resp_valid (resp_write=1, resp_rdata=0), go IDLE.
//  RD_AR: arvalid=1 until arready, then go RD_R (arvalid falls same edge).
//  RD_R: rready=1. On rvalid: latch rdata/rresp, pulse resp_valid (resp_write=0), go IDLE.
//  Valids never wait on ready. Payload is held stable while valid and ready is low.
//   bready/rready are asserted only in WR_B/RD_R.
//  Minimum latency, accept edge -> resp_valid: 3 cycles for both reads and writes (ready/valid all
//   asserted immediately). Next command is accepted in the cycle resp_valid is high.
//  req_ready=1 only in IDLE, so back-to-back throughput is 1 command per 3 cycles minimum.
//  Slave responses (bvalid/rvalid) outside WR_B/RD_R are ignored. Error responses (SLVERR/DECERR)
//   complete normally with resp_err=1.
//  No timeout: a slave that never responds stalls the FSM until areset.
//  Reset mid-transaction: the transaction is abandoned with no resp_valid; the slave must be reset too.
// TESTING
//  1 Write, slave always ready, addr=0x10, wdata=0xDEADBEEF, wstrb=4'hF, bresp=0 ->
//    awvalid/wvalid high 1 cycle; resp_valid 3 cycles after accept; resp_code=0.
//  2 Write, wready 4 cycles after awready -> awvalid drops after its handshake, wvalid held
//    with stable 0xA5A5A5A5; single resp_valid after bvalid.
//  3 Read, addr=0x20, arready delayed 2 cycles, rvalid with rdata=0x12345678, rresp=2'b10 ->
//    resp_valid with rdata=0x12345678, resp_code=2, resp_err=1.
//  4 Stray bvalid/rvalid pulses in IDLE -> no resp_valid, no state change. Then 8 back-to-back
//    alternating write/read commands -> 8 resp_valid pulses, in order.
//  5 areset asserted while in WR_B -> awvalid/wvalid/bready low immediately, no resp_valid.
//    req_ready=1 one edge after release; a subsequent write completes normally.

Source files
------------

// File: rtl/axi4lite_cmd_master.sv
// axi4lite_cmd_master: single-beat command port to AXI4-Lite master, one transaction in flight.
// Responses are returned as a one-cycle resp_valid pulse with the received BRESP/RRESP.
module axi4lite_cmd_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter logic [2:0] PROT = 3'b000
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    resp_valid,
    output logic                    resp_write,
    output logic [1:0]              resp_code,
    output logic                    resp_err,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [2:0]              awprot,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [2:0]              arprot,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rvalid,
    output logic                    rready
);
    typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R} state_t;
    state_t state, state_next;
    logic up, aw_done, w_done, accept, b_hs, r_hs;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    // up keeps req_ready low until the first edge after reset release
    assign req_ready = up && state == IDLE;
    assign accept = req_valid && req_ready;
    assign b_hs = state == WR_B && bvalid;
    assign r_hs = state == RD_R && rvalid;
    assign awvalid = state == WR_AW_W && !aw_done;
    assign wvalid = state == WR_AW_W && !w_done;
    assign arvalid = state == RD_AR;
    assign bready = state == WR_B;
    assign rready = state == RD_R;
    assign awaddr = addr_q;
    assign araddr = addr_q;
    assign awprot = PROT;
    assign arprot = PROT;
    assign wdata = wdata_q;
    assign wstrb = wstrb_q;
    assign resp_err = resp_code != 2'b00;
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = req_write ? WR_AW_W : RD_AR;
            WR_AW_W: if ((aw_done || awready) && (w_done || wready)) state_next = WR_B;
            WR_B:    if (bvalid) state_next = IDLE;
            RD_AR:   if (arready) state_next = RD_R;
            RD_R:    if (rvalid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state      <= IDLE;
            up         <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            resp_valid <= 1'b0;
            resp_write <= 1'b0;
            resp_code  <= 2'b00;
            resp_rdata <= '0;
        end else begin
            state      <= state_next;
            up         <= 1'b1;
            resp_valid <= b_hs || r_hs;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (state == WR_AW_W) begin
                aw_done <= aw_done || awready;
                w_done  <= w_done || wready;
            end
            if (b_hs) begin
                resp_write <= 1'b1;
                resp_code  <= bresp;
                resp_rdata <= '0;
            end
            if (r_hs) begin
                resp_write <= 1'b0;
                resp_code  <= rresp;
                resp_rdata <= rdata;
            end
        end
    end
endmodule

// File: tb/tb_axi4lite_cmd_master.sv
// tb_axi4lite_cmd_master: directed vector table with a per-vector AXI slave model plus
// hand-written sequences for stray responses, back-to-back traffic and mid-transaction reset.
module tb_axi4lite_cmd_master;
    logic aclk = 0, areset = 1;
    logic req_valid = 0, req_write = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [3:0] req_wstrb = 0;
    logic req_ready, resp_valid, resp_write, resp_err;
    logic [1:0] resp_code;
    logic [31:0] resp_rdata, awaddr, wdata, araddr;
    logic [2:0] awprot, arprot;
    logic [3:0] wstrb;
    logic awvalid, wvalid, arvalid, bready, rready;
    logic awready = 0, wready = 0, arready = 0, bvalid = 0, rvalid = 0;
    logic [1:0] bresp = 0, rresp = 0;
    logic [31:0] rdata = 0;
    int n_tests = 0, n_fail = 0;

    typedef struct {
        logic write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0] wstrb;
        int aw_dly, w_dly, ar_dly, rsp_dly;
        logic [1:0] resp;
        logic [31:0] rdata;
        int lat;
    } vec_t;
    vec_t vecs[8];

    axi4lite_cmd_master dut (
        .aclk(aclk), .areset(areset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_write(resp_write), .resp_code(resp_code),
        .resp_err(resp_err), .resp_rdata(resp_rdata),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Presents the command and returns after its accept edge; waited = cycles spent before accept
    task automatic issue(input vec_t v, output int waited);
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        req_valid = 1; req_write = v.write; req_addr = v.addr;
        req_wdata = v.wdata; req_wstrb = v.wstrb;
        waited = 0;
        while (!req_ready && waited < 20) begin
            step();
            waited++;
        end
        chk("req_ready_wait", {63'd0, req_ready}, 64'd1);
        step();
        req_valid = 0;
    endtask

    task automatic run_vec(input vec_t v, output int waited);
        int bcnt = 0, lat = 0;
        logic got = 0;
        issue(v, waited);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (resp_valid) begin
                got = 1;
                lat = cyc;
                break;
            end
            chk("awvalid", {63'd0, awvalid}, {63'd0, v.write && cyc <= v.aw_dly + 1});
            chk("wvalid", {63'd0, wvalid}, {63'd0, v.write && cyc <= v.w_dly + 1});
            chk("arvalid", {63'd0, arvalid}, {63'd0, !v.write && cyc <= v.ar_dly + 1});
            if (v.write) chk("rready_on_write", {63'd0, rready}, 64'd0);
            else chk("bready_on_read", {63'd0, bready}, 64'd0);
            if (awvalid) chk("awaddr", {29'd0, awprot, awaddr}, {32'd0, v.addr});
            if (wvalid) chk("wdata", {28'd0, wstrb, wdata}, {28'd0, v.wstrb, v.wdata});
            if (arvalid) chk("araddr", {29'd0, arprot, araddr}, {32'd0, v.addr});
            awready = cyc > v.aw_dly;
            wready = cyc > v.w_dly;
            arready = cyc > v.ar_dly;
            bvalid = bready && bcnt >= v.rsp_dly;
            rvalid = rready && bcnt >= v.rsp_dly;
            if (bready || rready) bcnt++;
            bresp = v.resp; rresp = v.resp; rdata = v.rdata;
            step();
        end
        chk("resp_seen", {63'd0, got}, 64'd1);
        chk("latency", lat, v.lat);
        chk("resp_write", {63'd0, resp_write}, {63'd0, v.write});
        chk("resp_code", {62'd0, resp_code}, {62'd0, v.resp});
        chk("resp_err", {63'd0, resp_err}, {63'd0, v.resp != 2'b00});
        chk("resp_rdata", {32'd0, resp_rdata}, {32'd0, v.write ? 32'd0 : v.rdata});
        chk("ready_in_resp", {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        int waited;
        vec_t v;
        vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0, 3};
        vecs[1] = '{1'b1, 32'h14, 32'hA5A5A5A5, 4'hF, 0, 4, 0, 0, 2'b00, 32'h0, 7};
        vecs[2] = '{1'b0, 32'h20, 32'h0, 4'h0, 0, 0, 2, 0, 2'b10, 32'h12345678, 5};
        vecs[3] = '{1'b1, 32'h30, 32'h01020304, 4'h5, 3, 0, 0, 2, 2'b11, 32'h0, 8};
        vecs[4] = '{1'b0, 32'h40, 32'h0, 4'h0, 0, 0, 0, 3, 2'b00, 32'hCAFEF00D, 6};
        vecs[5] = '{1'b1, 32'h44, 32'h55AA55AA, 4'h3, 2, 2, 0, 0, 2'b01, 32'h0, 5};
        vecs[6] = '{1'b0, 32'h48, 32'h0, 4'h0, 0, 0, 0, 0, 2'b11, 32'h0BADF00D, 3};
        vecs[7] = '{1'b1, 32'h4C, 32'h77777777, 4'h8, 5, 1, 0, 0, 2'b00, 32'h0, 8};

        #2;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_valids", {58'd0, awvalid, wvalid, arvalid, bready, rready, resp_valid}, 64'd0);
        chk("rst_regs", {resp_rdata, awaddr}, 64'd0);
        step(); step();
        areset = 0;
        chk("ready_before_edge", {63'd0, req_ready}, 64'd0);
        step();
        chk("ready_after_release", {63'd0, req_ready}, 64'd1);

        foreach (vecs[i]) run_vec(vecs[i], waited);
        step();
        chk("single_pulse", {63'd0, resp_valid}, 64'd0);

        // Stray slave responses while idle must be ignored
        for (int i = 0; i < 4; i++) begin
            bvalid = i[0]; rvalid = !i[0]; bresp = 2'b10; rresp = 2'b11;
            step();
            chk("stray_resp", {62'd0, resp_valid, req_ready}, 64'd1);
        end
        bvalid = 0; rvalid = 0;

        for (int i = 0; i < 8; i++) begin
            v = '{i % 2 == 0, 32'h100 + 32'(i * 4), 32'h11111111 * 32'(i), 4'hF,
                  0, 0, 0, 0, 2'(i), 32'hA0000000 + 32'(i), 3};
            run_vec(v, waited);
            if (i > 0) chk("b2b_wait", waited, 0);
        end

        // Reset while waiting for B abandons the write
        v = '{1'b1, 32'h200, 32'hFEEDFACE, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0, 3};
        step();
        issue(v, waited);
        awready = 1; wready = 1;
        step();
        chk("in_wr_b", {61'd0, awvalid, wvalid, bready}, 64'd1);
        areset = 1;
        #1;
        chk("rst_mid_valids", {59'd0, awvalid, wvalid, bready, req_ready, resp_valid}, 64'd0);
        awready = 0; wready = 0;
        step();
        areset = 0;
        chk("rst_mid_ready0", {62'd0, req_ready, resp_valid}, 64'd0);
        step();
        chk("rst_mid_ready1", {62'd0, req_ready, resp_valid}, 64'd2);
        run_vec(v, waited);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
